// File: rtl/lstm_cell_seq.sv
// lstm_cell_seq: time-multiplexing controller placed in front of one lstm_cell.
// Holds x, a double-banked h and c for one layer, evaluates the N_H units one
// after another, drives the weight/bias addresses and writes the cell's o_c/o_h
// results back. Reads of h always come from the committed bank; new results go
// to the other bank and become visible when the timestep completes.
module lstm_cell_seq #(
    parameter int WIDTH    = 32,
    parameter int N_X      = 4,
    parameter int N_H      = 4,
    parameter int CELL_LAT = 2,
    localparam int XAW     = (N_X > 1) ? $clog2(N_X) : 1,
    localparam int HAW     = (N_H > 1) ? $clog2(N_H) : 1,
    localparam int WAW     = (N_H * N_X > 1) ? $clog2(N_H * N_X) : 1,
    localparam int UAW     = (N_H * N_H > 1) ? $clog2(N_H * N_H) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_x_wr_en,
    input  logic [XAW-1:0]   i_x_wr_addr,
    input  logic [WIDTH-1:0] i_x_wr_data,
    input  logic             i_seq_clr,
    input  logic [HAW-1:0]   i_h_rd_addr,
    output logic [WIDTH-1:0] o_h_rd_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_cell_clr,
    output logic             o_acc_x,
    output logic             o_acc_h,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_h,
    output logic [WIDTH-1:0] o_prev_state,
    output logic [WAW-1:0]   o_w_addr,
    output logic [UAW-1:0]   o_u_addr,
    output logic [HAW-1:0]   o_b_addr,
    input  logic [WIDTH-1:0] i_cell_c,
    input  logic [WIDTH-1:0] i_cell_h
);

    localparam int K  = (N_X > N_H) ? N_X : N_H;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int LW = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_ACC, S_WAIT, S_WB, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic             start_q;
    logic [HAW-1:0]   j_q, j_d;
    logic [KW-1:0]    k_q, k_d;
    logic [LW-1:0]    w_q, w_d;
    logic             bank_q, bank_d;

    logic [WIDTH-1:0] x_q [N_X];
    logic [WIDTH-1:0] h_q [2][N_H];
    logic [WIDTH-1:0] c_q [N_H];

    logic             cell_clr_q, acc_x_q, acc_h_q, busy_q, done_q;
    logic [WIDTH-1:0] x_out_q, h_out_q, prev_q;
    logic [WAW-1:0]   w_addr_q;
    logic [UAW-1:0]   u_addr_q;
    logic [HAW-1:0]   b_addr_q;

    logic             acc_x_d, acc_h_d, hold_d;
    logic [WIDTH-1:0] x_out_d, h_out_d, prev_d;
    logic [WAW-1:0]   w_addr_d;
    logic [UAW-1:0]   u_addr_d;
    logic [HAW-1:0]   b_addr_d;
    int               j_i, k_i;

    // Next-state logic: unit index j, element index k, latency wait counter, bank.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned, which would infer a latch.
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        w_d     = w_q;
        bank_d  = bank_q;
        unique case (state_q)
            S_IDLE: if (start_q) begin
                state_d = S_CLR;
                j_d     = '0;
            end
            S_CLR: begin
                state_d = S_ACC;
                k_d     = '0;
            end
            S_ACC: if (k_q == KW'(K - 1)) begin
                state_d = S_WAIT;
                w_d     = '0;
            end else begin
                k_d = k_q + 1'b1;
            end
            S_WAIT: if (w_q == LW'(CELL_LAT - 1)) begin
                state_d = S_WB;
            end else begin
                w_d = w_q + 1'b1;
            end
            S_WB: if (j_q == HAW'(N_H - 1)) begin
                state_d = S_DONE;
            end else begin
                j_d     = j_q + 1'b1;
                state_d = S_CLR;
            end
            S_DONE: begin
                state_d = S_IDLE;
                bank_d  = ~bank_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the state being entered, so the registered outputs line up with it.
    always_comb begin
        j_i      = int'(j_d);
        k_i      = int'(k_d);
        hold_d   = (state_d == S_ACC) || (state_d == S_WAIT) || (state_d == S_WB);
        acc_x_d  = (state_d == S_ACC) && (k_i < N_X);
        acc_h_d  = (state_d == S_ACC) && (k_i < N_H);
        x_out_d  = acc_x_d ? x_q[k_d[XAW-1:0]] : '0;
        h_out_d  = acc_h_d ? h_q[bank_q][k_d[HAW-1:0]] : '0;
        w_addr_d = acc_x_d ? WAW'(j_i * N_X + k_i) : '0;
        u_addr_d = acc_h_d ? UAW'(j_i * N_H + k_i) : '0;
        b_addr_d = hold_d ? j_d : '0;
        prev_d   = hold_d ? c_q[j_d] : '0;
    end

    // FSM state, counters and registered outputs. A start request is registered
    // for one cycle first, and further requests are ignored until back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            j_q        <= '0;
            k_q        <= '0;
            w_q        <= '0;
            bank_q     <= 1'b0;
            cell_clr_q <= 1'b0;
            acc_x_q    <= 1'b0;
            acc_h_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            x_out_q    <= '0;
            h_out_q    <= '0;
            prev_q     <= '0;
            w_addr_q   <= '0;
            u_addr_q   <= '0;
            b_addr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            state_q    <= state_d;
            start_q    <= i_start && (state_q == S_IDLE) && !start_q;
            j_q        <= j_d;
            k_q        <= k_d;
            w_q        <= w_d;
            bank_q     <= bank_d;
            cell_clr_q <= (state_d == S_CLR);
            acc_x_q    <= acc_x_d;
            acc_h_q    <= acc_h_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
            x_out_q    <= x_out_d;
            h_out_q    <= h_out_d;
            prev_q     <= prev_d;
            w_addr_q   <= w_addr_d;
            u_addr_q   <= u_addr_d;
            b_addr_q   <= b_addr_d;
        end
    end

    // State vectors: x loads and sequence clears only while idle, write-back in WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these arrays must come up zeroed, so they are reset flops rather than a RAM macro.
            for (int i = 0; i < N_X; i++) x_q[i] <= '0;
            for (int i = 0; i < N_H; i++) begin
                h_q[0][i] <= '0;
                h_q[1][i] <= '0;
                c_q[i]    <= '0;
            end
        end else begin
            if (state_q == S_IDLE) begin
                if (i_x_wr_en) x_q[i_x_wr_addr] <= i_x_wr_data;
                if (i_seq_clr) begin
                    for (int i = 0; i < N_H; i++) begin
                        h_q[0][i] <= '0;
                        h_q[1][i] <= '0;
                        c_q[i]    <= '0;
                    end
                end
            end
            if (state_q == S_WB) begin
                c_q[j_q]          <= i_cell_c;
                h_q[~bank_q][j_q] <= i_cell_h;
            end
        end
    end

    assign o_h_rd_data  = h_q[bank_q][i_h_rd_addr];
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_cell_clr   = cell_clr_q;
    assign o_acc_x      = acc_x_q;
    assign o_acc_h      = acc_h_q;
    assign o_x          = x_out_q;
    assign o_h          = h_out_q;
    assign o_prev_state = prev_q;
    assign o_w_addr     = w_addr_q;
    assign o_u_addr     = u_addr_q;
    assign o_b_addr     = b_addr_q;

endmodule

// File: tb/tb_lstm_cell_seq.sv
// tb_lstm_cell_seq: main instance (N_X=2, N_H=2, CELL_LAT=2) checked every
// cycle against an expected-cycle queue built from the timestep schedule, plus
// a second instance (N_X=3, N_H=1, CELL_LAT=1) for unequal vector lengths.
module tb_lstm_cell_seq;

    localparam int NX = 2, NH = 2, CL = 2, K = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        i_start = 1'b0, i_x_wr_en = 1'b0, i_seq_clr = 1'b0;
    logic [0:0]  i_x_wr_addr = '0;
    logic [31:0] i_x_wr_data = '0;
    logic [0:0]  i_h_rd_addr = '0;
    logic [31:0] o_h_rd_data, o_x, o_h, o_prev_state;
    logic        o_busy, o_done, o_cell_clr, o_acc_x, o_acc_h;
    logic [1:0]  o_w_addr, o_u_addr;
    logic [0:0]  o_b_addr;
    logic [31:0] stub_h_base = '0, stub_c_base = '0;
    logic [31:0] cell_c, cell_h;

    // Stub cell: its outputs identify the unit being written back.
    assign cell_h = stub_h_base + 32'(o_b_addr);
    assign cell_c = stub_c_base + 32'(o_b_addr);

    lstm_cell_seq #(.WIDTH(32), .N_X(NX), .N_H(NH), .CELL_LAT(CL)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_x_wr_en(i_x_wr_en),
        .i_x_wr_addr(i_x_wr_addr), .i_x_wr_data(i_x_wr_data), .i_seq_clr(i_seq_clr),
        .i_h_rd_addr(i_h_rd_addr), .o_h_rd_data(o_h_rd_data), .o_busy(o_busy),
        .o_done(o_done), .o_cell_clr(o_cell_clr), .o_acc_x(o_acc_x), .o_acc_h(o_acc_h),
        .o_x(o_x), .o_h(o_h), .o_prev_state(o_prev_state), .o_w_addr(o_w_addr),
        .o_u_addr(o_u_addr), .o_b_addr(o_b_addr), .i_cell_c(cell_c), .i_cell_h(cell_h)
    );

    // Second instance with N_X=3, N_H=1, CELL_LAT=1.
    logic        s_start = 1'b0;
    logic [31:0] s_rd, s_x, s_h, s_prev;
    logic        s_busy, s_done, s_clr, s_acc_x, s_acc_h;
    logic [1:0]  s_w_addr;
    logic [0:0]  s_u_addr, s_b_addr;

    lstm_cell_seq #(.WIDTH(32), .N_X(3), .N_H(1), .CELL_LAT(1)) dut_s (
        .clk(clk), .rst(rst), .i_start(s_start), .i_x_wr_en(1'b0),
        .i_x_wr_addr(2'b00), .i_x_wr_data(32'h0), .i_seq_clr(1'b0),
        .i_h_rd_addr(1'b0), .o_h_rd_data(s_rd), .o_busy(s_busy),
        .o_done(s_done), .o_cell_clr(s_clr), .o_acc_x(s_acc_x), .o_acc_h(s_acc_h),
        .o_x(s_x), .o_h(s_h), .o_prev_state(s_prev), .o_w_addr(s_w_addr),
        .o_u_addr(s_u_addr), .o_b_addr(s_b_addr), .i_cell_c(32'h00000123), .i_cell_h(32'h00000456)
    );

    typedef struct packed {
        logic        clr;
        logic        ax;
        logic        ah;
        logic [31:0] x;
        logic [31:0] h;
        logic [31:0] prev;
        logic [1:0]  wa;
        logic [1:0]  ua;
        logic [0:0]  ba;
        logic        busy;
        logic        done;
    } rec_t;

    int   total = 0, bad = 0;
    int   cyc = 0, start_cyc = 0, done_off = -1;
    bit   log_en = 1'b0;
    int   clr_log[$];
    int   wa_log[$];
    rec_t exp_q[$];

    // Model of the architectural state visible to the bench.
    logic [31:0] x_m [NX];
    logic [31:0] h_vis [NH];
    logic [31:0] pend_h [NH];
    logic [31:0] c_m [NH];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic zero_state();
        for (int i = 0; i < NH; i++) begin
            h_vis[i]  = '0;
            pend_h[i] = '0;
            c_m[i]    = '0;
        end
    endtask

    // Expected cycle-by-cycle outputs for one timestep: per unit one clear cycle,
    // K accumulate cycles, CELL_LAT wait cycles and one write-back; then done.
    task automatic build_step();
        rec_t r;
        for (int j = 0; j < NH; j++) begin
            r = '0; r.busy = 1'b1; r.clr = 1'b1;
            exp_q.push_back(r);
            for (int k = 0; k < K; k++) begin
                r = '0; r.busy = 1'b1; r.ba = 1'(j); r.prev = c_m[j];
                if (k < NX) begin r.ax = 1'b1; r.x = x_m[k]; r.wa = 2'(j * NX + k); end
                if (k < NH) begin r.ah = 1'b1; r.h = h_vis[k]; r.ua = 2'(j * NH + k); end
                exp_q.push_back(r);
            end
            for (int w = 0; w < CL + 1; w++) begin
                r = '0; r.busy = 1'b1; r.ba = 1'(j); r.prev = c_m[j];
                exp_q.push_back(r);
            end
        end
        r = '0; r.busy = 1'b1; r.done = 1'b1;
        exp_q.push_back(r);
        for (int j = 0; j < NH; j++) begin
            pend_h[j] = stub_h_base + 32'(j);
            c_m[j]    = stub_c_base + 32'(j);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every cycle, outputs against the expected queue (idle when empty).
    always @(negedge clk) begin
        rec_t a_r, e_r;
        a_r.clr = o_cell_clr;  a_r.ax = o_acc_x;  a_r.ah = o_acc_h;
        a_r.x = o_x;  a_r.h = o_h;  a_r.prev = o_prev_state;
        a_r.wa = o_w_addr;  a_r.ua = o_u_addr;  a_r.ba = o_b_addr;
        a_r.busy = o_busy;  a_r.done = o_done;
        e_r = '0;
        if (exp_q.size() > 0) e_r = exp_q.pop_front();
        check($sformatf("cycle%0d", cyc), 128'(a_r), 128'(e_r));
        check($sformatf("rd_data%0d", cyc), 128'(o_h_rd_data), 128'(h_vis[i_h_rd_addr]));
        if (log_en) begin
            if (o_cell_clr) clr_log.push_back(cyc - start_cyc);
            if (o_acc_x)    wa_log.push_back(int'(o_w_addr));
            if (o_done)     done_off = cyc - start_cyc;
        end
    end

    task automatic write_x(input int a, input logic [31:0] d);
        i_x_wr_en = 1'b1; i_x_wr_addr = 1'(a); i_x_wr_data = d;
        @(posedge clk); #1;
        i_x_wr_en = 1'b0;
        x_m[a] = d;
    endtask

    task automatic run_step(input logic [31:0] hb, input logic [31:0] cb,
                            input bit disturb, input bit clr_too, input bit log_it);
        stub_h_base = hb; stub_c_base = cb;
        clr_log.delete(); wa_log.delete(); done_off = -1;
        i_start = 1'b1; i_seq_clr = clr_too;
        @(posedge clk); #1;
        i_start = 1'b0; i_seq_clr = 1'b0;
        if (clr_too) zero_state();
        start_cyc = cyc; log_en = log_it;
        @(posedge clk); #1;
        build_step();
        for (int n = 1; n < 100 && exp_q.size() > 0; n++) begin
            i_h_rd_addr = 1'(n % NH);
            if (disturb && n == 3) begin
                i_start = 1'b1; i_seq_clr = 1'b1;
                i_x_wr_en = 1'b1; i_x_wr_addr = 1'b0; i_x_wr_data = 32'hDEADBEEF;
            end
            if (n == 4) begin
                i_start = 1'b0; i_seq_clr = 1'b0; i_x_wr_en = 1'b0;
            end
            @(posedge clk); #1;
        end
        log_en = 1'b0;
        if (exp_q.size() != 0) begin
            check("step_drain", 128'(exp_q.size()), 128'(0));
            exp_q.delete();
        end
        for (int i = 0; i < NH; i++) h_vis[i] = pend_h[i];
    endtask

    task automatic short_test();
        int nax, nah, ax_first, ah_at, done_at;
        nax = 0; nah = 0; ax_first = -1; ah_at = -2; done_at = -1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (s_acc_x) begin
                if (ax_first < 0) ax_first = i;
                check("s_w_addr", 128'(s_w_addr), 128'(nax));
                nax++;
            end
            if (s_acc_h) begin
                nah++; ah_at = i;
                check("s_h", 128'(s_h), 128'(0));
                check("s_u_addr", 128'(s_u_addr), 128'(0));
            end
            if (s_done) begin done_at = i; break; end
        end
        check("s_acc_x_cycles", 128'(nax), 128'(3));
        check("s_acc_h_cycles", 128'(nah), 128'(1));
        check("s_acc_h_first", 128'(ah_at), 128'(ax_first));
        check("s_done_latency", 128'(done_at), 128'(7));
    endtask

    initial begin
        for (int i = 0; i < NX; i++) x_m[i] = '0;
        zero_state();

        // Reset held: idle outputs and zero readback for every index.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            i_h_rd_addr = 1'(i % NH);
        end
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        short_test();

        // First timestep with x = {1.0, 2.0}, pinned by literal expectations.
        write_x(0, 32'h01000000);
        write_x(1, 32'h02000000);
        run_step(32'h00800000, 32'h00300000, 1'b0, 1'b0, 1'b1);
        check("clr_count", 128'(clr_log.size()), 128'(2));
        check("clr_first", 128'((clr_log.size() > 0) ? clr_log[0] : -1), 128'(1));
        check("clr_second", 128'((clr_log.size() > 1) ? clr_log[1] : -1), 128'(7));
        check("w_addr_count", 128'(wa_log.size()), 128'(4));
        for (int i = 0; i < wa_log.size(); i++) check("w_addr_seq", 128'(wa_log[i]), 128'(i));
        check("done_latency", 128'(done_off), 128'(13));
        i_h_rd_addr = 1'b0; #1;
        check("rd_h0_lit", 128'(o_h_rd_data), 128'(32'h00800000));
        i_h_rd_addr = 1'b1; #1;
        check("rd_h1_lit", 128'(o_h_rd_data), 128'(32'h00800001));

        // Recurrence, with start / x write / sequence clear issued while busy.
        run_step(32'h00900000, 32'h00400000, 1'b1, 1'b0, 1'b0);
        i_h_rd_addr = 1'b1; #1;
        check("rd_h1_run2_lit", 128'(o_h_rd_data), 128'(32'h00900001));
        run_step(32'h00A00000, 32'h00500000, 1'b0, 1'b0, 1'b0);

        // Sequence clear while idle.
        i_seq_clr = 1'b1;
        @(posedge clk); #1;
        i_seq_clr = 1'b0;
        zero_state();
        i_h_rd_addr = 1'b0; #1;
        check("rd_after_clr_lit", 128'(o_h_rd_data), 128'(0));
        run_step(32'h00B00000, 32'h00600000, 1'b0, 1'b0, 1'b0);

        // Start together with sequence clear: runs from zero state.
        run_step(32'h00C00000, 32'h00700000, 1'b0, 1'b1, 1'b0);

        // Reset asserted in the middle of ACC.
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        build_step();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NX; i++) x_m[i] = '0;
        zero_state();
        for (int a = 0; a < NH; a++) begin
            i_h_rd_addr = 1'(a); #1;
            check("rst_rd_lit", 128'(o_h_rd_data), 128'(0));
        end
        check("rst_busy_lit", 128'(o_busy), 128'(0));
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        run_step(32'h00D00000, 32'h00800000, 1'b0, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lstm_cell_seq.md
Name: lstm_cell_seq

Overview:
- Time-multiplexing controller that sits directly upstream of lstm_cell and feeds it.
- Holds the current input vector x, the hidden-state vector h (double-banked) and the cell-state vector c for one LSTM layer of N_H units.
- Evaluates the units one after another on a single lstm_cell:
  - streams x/h elements while driving acc_x/acc_h;
  - generates weight/bias addresses;
  - captures o_c/o_h back into its state buffers.

Parameters:
- WIDTH, 32, data word width; Q8.24 fixed point (32'h01000000 = 1.0).
- N_X, 4, input vector length (>=1).
- N_H, 4, hidden units per layer (>=1).
- CELL_LAT, 2, cycles from the last accumulate cycle until the cell's o_c/o_h are valid (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- i_start  in  1  start one timestep.
- i_x_wr_en  in  1  write x element.
- i_x_wr_addr  in  clog2(N_X)  x element index.
- i_x_wr_data  in  WIDTH  x element value.
- i_seq_clr  in  1  zero h and c (new sequence).
- i_h_rd_addr  in  clog2(N_H)  hidden readback index.
- o_h_rd_data  out  WIDTH  h_cur[i_h_rd_addr], combinational.
- o_busy  out  1  timestep in progress.
- o_done  out  1  one-cycle completion pulse.
- o_cell_clr  out  1  clears the cell accumulators.
- o_acc_x  out  1  to cell acc_x.
- o_acc_h  out  1  to cell acc_h.
- o_x  out  WIDTH  to cell i_x.
- o_h  out  WIDTH  to cell i_h.
- o_prev_state  out  WIDTH  to cell i_prev_state.
- o_w_addr  out  clog2(N_H*N_X)  W-matrix address.
- o_u_addr  out  clog2(N_H*N_H)  U-matrix address.
- o_b_addr  out  clog2(N_H)  bias address.
- i_cell_c  in  WIDTH  from cell o_c.
- i_cell_h  in  WIDTH  from cell o_h.

Behaviour:
- Interface (already decided): one clock, clk. rst is asynchronous, active-high.
- Reset values:
  - All outputs 0.
  - FSM in IDLE; unit index j=0; k=0; bank=0.
  - x, both h banks and c all zero.
- Weight storage is external with asynchronous read. Addresses are valid in the same cycle as the strobes they accompany.
- Constant: K = max(N_X, N_H).
- FSM states:
  - IDLE:
    - i_start moves to CLR and sets j=0.
    - i_seq_clr zeroes both h banks and all c in one cycle. If i_start and i_seq_clr are both high, the clear applies first and the timestep uses zeros.
    - x writes are accepted only in IDLE; writes in any other state are dropped.
  - CLR: o_cell_clr=1 for exactly 1 cycle; k=0; go to ACC.
  - ACC: K cycles, k=0..K-1.
    - o_acc_x = (k<N_X); o_x = x[k]; o_w_addr = j*N_X + k.
    - o_acc_h = (k<N_H); o_h = h[bank][k]; o_u_addr = j*N_H + k.
    - When a strobe is low, its data and address outputs are 0.
    - o_b_addr = j and o_prev_state = c[j], held from ACC through WB.
    - After k=K-1, go to WAIT.
  - WAIT: CELL_LAT cycles, all strobes low; then WB.
  - WB: 1 cycle.
    - Write c[j] <= i_cell_c (in place) and h[~bank][j] <= i_cell_h.
    - If j==N_H-1, go to DONE; else j++ and go to CLR.
  - DONE: 1 cycle; o_done=1; bank toggles; go to IDLE.
- o_busy=1 in every state except IDLE. i_start is ignored while busy.
- Latency: o_done rises N_H*(K+CELL_LAT+2)+1 cycles after the edge that samples i_start.
- Arithmetic: none on data. Index arithmetic is unsigned. There is no wrap-around at the maximum index because the counters are bounded by the FSM.
- o_h_rd_data always reads the committed bank, so it is stable for the whole of a timestep.
- rst mid-operation: immediate return to the reset state. Partial results are discarded and state vectors are zeroed.
- i_seq_clr while busy is ignored.

Test Plan:
- Reset/idle: rst high mid-ACC (N_X=2, N_H=2, CELL_LAT=2), then release.
  - Required: all outputs 0, o_busy=0, o_h_rd_data=0 for every index.
- Single timestep, N_X=2, N_H=2, CELL_LAT=2. Write x={32'h01000000, 32'h02000000}, pulse i_start.
  - o_cell_clr pulses at cycles 1 and 7.
  - o_acc_x/o_acc_h high for 2 cycles per unit.
  - o_w_addr sequence 0,1 then 2,3.
  - o_done exactly 13 cycles after start.
  - With a stub cell returning h=32'h00800000+j, o_h_rd_data(0)=32'h00800000 and o_h_rd_data(1)=32'h00800001 after done.
- Unequal lengths, N_X=3, N_H=1. Per unit: o_acc_x high for 3 cycles; o_acc_h high for the first cycle only with o_h=0 and o_u_addr=j.
- Recurrence: run two timesteps.
  - The second timestep's o_h stream equals the first timestep's stub outputs.
  - o_prev_state for unit j equals the stub's c from the prior timestep.
  - o_h_rd_data does not change during the second run until its o_done.
- Guards:
  - i_start and an x write while busy → ignored: no restart, and x is unchanged at the next timestep.
  - i_seq_clr in IDLE → o_h_rd_data=0 and the next o_prev_state=0.
  - i_start and i_seq_clr together → timestep runs from zero state.
